// File: rtl/adder_pkg.sv
// Shared constants for the serial chunk adder: FSM encoding and default geometry.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder used once per cycle by the serial adder.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out
);

    logic c;

    always_comb begin
        sum = '0;
        c   = carry_in;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder summing CHUNK bits per cycle; result registers update only on completion.
// Define OVERFLOW_FLAG_EN to register two's-complement overflow; otherwise overflow is tied to 0.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              done_q, done_d;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
`ifdef OVERFLOW_FLAG_EN
    logic              ovf_q, ovf_d;
`endif

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .a        (a_q[idx_q*CHUNK +: CHUNK]),
        .b        (b_q[idx_q*CHUNK +: CHUNK]),
        .carry_in (carry_q),
        .sum      (chunk_sum),
        .carry_out(chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // work_d already holds the final chunk, so the result is complete here.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = chunk_cout;
                    done_d  = 1'b1;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign overflow  = ovf_q;
`else
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder: 16/4 and 5/5 instances against an arithmetic model.
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        start5, cin5;
    logic [4:0]  a5, b5;
    logic        busy5, done5, cout5, ovf5;
    logic [4:0]  sum5;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_sum, pend_sum;
    logic        exp_c, exp_o, pend_c, pend_o;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
        .busy(busy), .done(done), .sum(sum), .carry_out(cout), .overflow(ovf)
    );

    serial_chunk_adder #(.WIDTH(5), .CHUNK(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .carry_in(cin5),
        .busy(busy5), .done(done5), .sum(sum5), .carry_out(cout5), .overflow(ovf5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ovf_model(input logic ma, input logic mb, input logic ms);
`ifdef OVERFLOW_FLAG_EN
        return (ma == mb) && (ms != ma);
`else
        return 1'b0 & ma & mb & ms;
`endif
    endfunction

    // Present one start cycle; operands are scrambled afterwards to prove they were latched.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc);
        logic [16:0] res;
        a = ta; b = tbv; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        res = {1'b0, ta} + {1'b0, tbv} + 17'(tc);
        pend_sum = res[15:0];
        pend_c   = res[16];
        pend_o   = ovf_model(ta[15], tbv[15], res[15]);
    endtask

    // Returns at the done cycle; elapsed = cycles already spent since the start edge.
    task automatic wait_done(input string tag, input int elapsed);
        int cyc = elapsed;
        while (done !== 1'b1 && cyc < 20) begin
            check({tag, ":busy"}, 32'(busy), 32'd1);
            check({tag, ":hold"}, 32'(sum), 32'(exp_sum));
            tick();
            cyc++;
        end
        check({tag, ":latency"}, cyc, 4);
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":busy_end"}, 32'(busy), 32'd0);
        check({tag, ":sum"}, 32'(sum), 32'(pend_sum));
        check({tag, ":cout"}, 32'(cout), 32'(pend_c));
        check({tag, ":ovf"}, 32'(ovf), 32'(pend_o));
        exp_sum = pend_sum; exp_c = pend_c; exp_o = pend_o;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, ":no_done"}, 32'(done), 32'd0);
            check({tag, ":idle"}, 32'(busy), 32'd0);
            check({tag, ":held"}, {15'd0, exp_o, exp_c, sum}, {15'd0, exp_o, exp_c, exp_sum});
        end
    endtask

    initial begin
        logic [5:0] r5;
        logic [4:0] ta5, tb5;
        logic       tc5;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
        exp_sum = '0; exp_c = 1'b0; exp_o = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        check("rst_busy5_sum5", {26'd0, busy5, sum5}, 32'd0);
        rst = 1'b0;
        tick();

        start_op(16'hAAAA, 16'h5555, 1'b0);
        wait_done("aa55_c0", 0);
        check("aa55_c0_sum_const", 32'(sum), 32'h0000_FFFF);
        check("aa55_c0_cout_const", 32'(cout), 32'd0);
        idle("aa55_c0", 1);

        start_op(16'hAAAA, 16'h5555, 1'b1);
        wait_done("aa55_c1", 0);
        check("aa55_c1_sum_const", 32'(sum), 32'd0);
        check("aa55_c1_cout_const", 32'(cout), 32'd1);
        idle("aa55_c1", 2);

        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done("ovf", 0);
        check("ovf_sum_const", 32'(sum), 32'h0000_8000);
`ifdef OVERFLOW_FLAG_EN
        check("ovf_flag_const", 32'(ovf), 32'd1);
`else
        check("ovf_flag_const", 32'(ovf), 32'd0);
`endif
        idle("ovf", 1);

        // A second start two cycles into a run must be ignored.
        start_op(16'h1234, 16'h4321, 1'b0);
        tick();
        tick();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore", 3);
        check("ignore_sum_const", 32'(sum), 32'h0000_5555);
        idle("ignore", 6);

        // Reset mid-run aborts with no done pulse and clears the result.
        start_op(16'hF00F, 16'h0FF1, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_sum = '0; exp_c = 1'b0; exp_o = 1'b0;
        idle("abort", 6);
        start_op(16'h0F0F, 16'hF0F1, 1'b0);
        wait_done("after_abort", 0);
        idle("after_abort", 1);

        // Random operands; skipping idle makes the next start land in the done cycle.
        for (int i = 0; i < 30; i++) begin
            start_op(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done($sformatf("rnd%0d", i), 0);
            if ($urandom_range(0, 1) == 0) idle($sformatf("rnd%0d", i), $urandom_range(1, 3));
        end
        idle("rnd_end", 1);

        // Single-chunk instance: one RUN cycle, so done follows start by one edge.
        a5 = 5'b10101; b5 = 5'b01010; cin5 = 1'b1; start5 = 1'b1;
        tick();
        start5 = 1'b0;
        check("w5_busy", 32'(busy5), 32'd1);
        check("w5_early_done", 32'(done5), 32'd0);
        tick();
        check("w5_done", 32'(done5), 32'd1);
        check("w5_sum", 32'(sum5), 32'd0);
        check("w5_cout", 32'(cout5), 32'd1);
        check("w5_ovf", 32'(ovf5), 32'd0);
        check("w5_busy_end", 32'(busy5), 32'd0);
        tick();
        check("w5_pulse", 32'(done5), 32'd0);

        for (int i = 0; i < 12; i++) begin
            ta5 = 5'($urandom); tb5 = 5'($urandom); tc5 = 1'($urandom);
            a5 = ta5; b5 = tb5; cin5 = tc5; start5 = 1'b1;
            tick();
            start5 = 1'b0;
            a5 = 5'($urandom); b5 = 5'($urandom);
            r5 = {1'b0, ta5} + {1'b0, tb5} + 6'(tc5);
            check($sformatf("w5r%0d_busy", i), 32'(busy5), 32'd1);
            tick();
            check($sformatf("w5r%0d_done", i), 32'(done5), 32'd1);
            check($sformatf("w5r%0d_res", i), {25'd0, ovf5, cout5, sum5},
                  {25'd0, ovf_model(ta5[4], tb5[4], r5[4]), r5});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
